// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder that time-shares one 4-bit carry-lookahead slice, LSB nibble first.
// Optional subtract mode (op_sub port) is built when CLA_SEQ_SUB_EN is defined.

module PGCalc (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign sum  = p ^ c[3:0];
    assign cout = c[4];
endmodule

module cla_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             op_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
        $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry_q;
    logic [KW-1:0]     k_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  b_in;
    logic              c_in;
    logic [KW+1:0]     base;
    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        s_sum;
    logic              s_cout;
    logic              last;

`ifdef CLA_SEQ_SUB_EN
    // Subtraction stores ~b and forces carry-in so the slice computes a + ~b + 1.
    assign b_in = op_sub ? ~b : b;
    assign c_in = op_sub ? 1'b1 : cin;
`else
    assign b_in = b;
    assign c_in = cin;
`endif

    assign base  = {k_q, 2'b00};
    assign nib_a = a_q[base +: 4];
    assign nib_b = b_q[base +: 4];
    assign last  = (k_q == KW'(NSLICE - 1));

    PGCalc u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (last)      next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        k_q     <= '0;
                    end
                end
                RUN: begin
                    sum_q[base +: 4] <= s_sum;
                    carry_q          <= s_cout;
                    if (last) begin
                        cout_q <= s_cout;
                        // Carry into the top bit is recovered from the last nibble's bit 3.
                        ovf_q  <= (nib_a[3] ^ nib_b[3] ^ s_sum[3]) ^ s_cout;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (WIDTH=16); subtract vectors run when CLA_SEQ_SUB_EN is defined.

module tb_cla_seq_adder;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks;
    int errors;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Accept one transaction, measure latency, check the held result, then consume it.
    task automatic run_txn(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tcin, input logic tsub, input logic [15:0] esum,
                           input logic ecout, input logic eovf);
        int cyc;
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; op_sub = tsub; in_valid = 1'b1;
        check({tag, ".in_ready"}, in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~tcin; op_sub = ~tsub;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, cyc, 4);
        check({tag, ".sum"}, sum, esum);
        check({tag, ".cout"}, cout, ecout);
        check({tag, ".ovf"}, ovf, eovf);
        check({tag, ".busy"}, in_ready, 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, ".back_idle"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        logic [15:0] held;
        checks = 0; errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
        #12;
        check("reset.outs", {in_ready, out_valid, cout, ovf}, 4'b1000);
        check("reset.sum", sum, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("basic",    16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        run_txn("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_txn("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_txn("cin",      16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_txn("negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_txn("allones",  16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        run_txn("mixed",    16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);

        // Backpressure: result must hold and a new request must be refused.
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("bp.valid", out_valid, 1'b1);
        held = sum;
        check("bp.sum", held, 16'h3333);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp.hold_sum", sum, 16'h3333);
            check("bp.hold_flags", {out_valid, in_ready}, 2'b10);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp.pre_release", in_ready, 1'b0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp.release", {out_valid, in_ready}, 2'b01);
        @(posedge clk); #1;
        check("bp.no_accept", {out_valid, in_ready}, 2'b01);

        // Abort mid-RUN with asynchronous reset.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort.outs", {in_ready, out_valid, cout, ovf}, 4'b1000);
        check("abort.sum", sum, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn("post_abort", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        run_txn("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_txn("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
